// File: rtl/mmio_bus_bridge_if.sv
// rtl/mmio_bus_bridge_if.sv - core data port and memory port bundle for the MMIO bridge
interface mmio_bus_bridge_if;
    logic        coreRead;
    logic        coreWrite;
    logic [31:0] coreAddr;
    logic [31:0] coreDataIn;
    logic [31:0] coreDataOut;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memDataIn;
    logic [31:0] memDataOut;

    // Bridge side: consumes core requests, drives memory requests.
    modport slave (
        input  coreRead, coreWrite, coreAddr, coreDataIn, memDataOut,
        output coreDataOut, memRead, memWrite, memAddr, memDataIn
    );

    // Environment side: the core plus the RAM.
    modport master (
        output coreRead, coreWrite, coreAddr, coreDataIn, memDataOut,
        input  coreDataOut, memRead, memWrite, memAddr, memDataIn
    );
endinterface

// File: rtl/mmio_bus_bridge.sv
// rtl/mmio_bus_bridge.sv - routes core data accesses to RAM or LED/cycle/UART MMIO registers
module mmio_bus_bridge #(
    parameter int unsigned  BAUD_DIV  = 868,
    parameter logic [15:0]  MMIO_BASE = 16'hFFFF
) (
    input  logic              CLK,
    input  logic              RES,
    mmio_bus_bridge_if.slave  bus,
    output logic [31:0]       led,
    output logic              uart_tx
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam logic [15:0] BAUD_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [13:0] SEL_LED    = 14'd0;
    localparam logic [13:0] SEL_CYCLE  = 14'd1;
    localparam logic [13:0] SEL_TXDATA = 14'd2;
    localparam logic [13:0] SEL_STATUS = 14'd3;

    logic        mmio;
    logic [13:0] sel;
    logic        wr_led, wr_cycle, wr_tx, wr_status;
    logic        busy, tx_accept, tx_drop;
    logic [31:0] cycle_cnt;
    logic        ovf;
    logic [31:0] mmio_rdata;

    uart_state_t state, state_next;
    logic [15:0] baud_cnt, baud_next;
    logic [2:0]  bit_idx, bit_next;
    logic [7:0]  tx_data, data_next;
    logic        tx_next;

    assign mmio = (bus.coreAddr[31:16] == MMIO_BASE);
    assign sel  = bus.coreAddr[15:2];

    // RAM side is pure wiring so RAM traffic sees no added latency.
    assign bus.memAddr   = bus.coreAddr;
    assign bus.memDataIn = bus.coreDataIn;
    assign bus.memRead   = bus.coreRead  & ~mmio;
    assign bus.memWrite  = bus.coreWrite & ~mmio;

    assign wr_led    = bus.coreWrite & mmio & (sel == SEL_LED);
    assign wr_cycle  = bus.coreWrite & mmio & (sel == SEL_CYCLE);
    assign wr_tx     = bus.coreWrite & mmio & (sel == SEL_TXDATA);
    assign wr_status = bus.coreWrite & mmio & (sel == SEL_STATUS);

    assign busy      = (state != IDLE);
    assign tx_accept = wr_tx & ~busy;
    assign tx_drop   = wr_tx & busy;

    always_comb begin
        mmio_rdata = 32'd0;
        case (sel)
            SEL_LED:    mmio_rdata = led;
            SEL_CYCLE:  mmio_rdata = cycle_cnt;
            SEL_STATUS: mmio_rdata = {30'd0, ovf, busy};
            default:    mmio_rdata = 32'd0;
        endcase
    end

    assign bus.coreDataOut = mmio ? mmio_rdata : bus.memDataOut;

    always_ff @(posedge CLK) begin
        if (!RES) begin
            led       <= 32'd0;
            cycle_cnt <= 32'd0;
            ovf       <= 1'b0;
        end else begin
            if (wr_led)
                led <= bus.coreDataIn;
            if (wr_cycle)
                cycle_cnt <= bus.coreDataIn;
            else
                cycle_cnt <= cycle_cnt + 32'd1;
            // A dropped byte wins over a same-cycle clear.
            if (tx_drop)
                ovf <= 1'b1;
            else if (wr_status && bus.coreDataIn[1])
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RES) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            tx_data  <= 8'd0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            tx_data  <= data_next;
            uart_tx  <= tx_next;
        end
    end

    // tx_next is the line level for the cycle after the edge, so each level
    // appears on uart_tx exactly when its state is entered.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        data_next  = tx_data;
        tx_next    = uart_tx;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (tx_accept) begin
                    state_next = START;
                    baud_next  = 16'd0;
                    bit_next   = 3'd0;
                    data_next  = bus.coreDataIn[7:0];
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    state_next = DATA;
                    baud_next  = 16'd0;
                    tx_next    = tx_data[0];
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next = 16'd0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                        tx_next  = tx_data[bit_idx + 3'd1];
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (baud_cnt == BAUD_LAST) begin
                    state_next = IDLE;
                    baud_next  = 16'd0;
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_mmio_bus_bridge.sv
// tb/tb_mmio_bus_bridge.sv - directed self-checking bench for mmio_bus_bridge
module tb_mmio_bus_bridge;
    localparam logic [31:0] A_LED    = 32'hFFFF0000;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF0004;
    localparam logic [31:0] A_TXDATA = 32'hFFFF0008;
    localparam logic [31:0] A_STATUS = 32'hFFFF000C;

    logic        CLK;
    logic        RES;
    logic [31:0] led;
    logic        uart_tx;

    mmio_bus_bridge_if bus ();

    mmio_bus_bridge #(.BAUD_DIV(4), .MMIO_BASE(16'hFFFF)) dut (
        .CLK     (CLK),
        .RES     (RES),
        .bus     (bus.slave),
        .led     (led),
        .uart_tx (uart_tx)
    );

    logic [31:0] mem [0:255];
    int          memwr_count;
    int          passed;
    int          total;
    logic [31:0] rdata;
    logic        rd_mem;
    logic        wr_mem;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign bus.memDataOut = mem[bus.memAddr[9:2]];

    always @(posedge CLK) begin
        if (bus.memWrite) begin
            mem[bus.memAddr[9:2]] <= bus.memDataIn;
            memwr_count <= memwr_count + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.coreAddr = a;
        bus.coreRead = 1'b1;
        #1;
        d = bus.coreDataOut;
        rd_mem = bus.memRead;
        bus.coreRead = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.coreAddr   = a;
        bus.coreDataIn = d;
        bus.coreWrite  = 1'b1;
        #1;
        wr_mem = bus.memWrite;
        cyc();
        bus.coreWrite = 1'b0;
    endtask

    // Call after edge 'first' of a frame whose accepting edge was edge 0.
    task automatic frame_check(input logic [7:0] b, input int first, input logic ovf_exp);
        logic [9:0]  lv;
        logic [31:0] st;
        lv = {1'b1, b, 1'b0};
        for (int i = first; i < 40; i++) begin
            chk($sformatf("frame_tx_%02h_c%0d", b, i), {31'd0, uart_tx}, {31'd0, lv[i/4]});
            rd(A_STATUS, st);
            chk($sformatf("frame_busy_%02h_c%0d", b, i), st, {30'd0, ovf_exp, 1'b1});
            cyc();
        end
        chk($sformatf("frame_end_tx_%02h", b), {31'd0, uart_tx}, 32'd1);
        rd(A_STATUS, st);
        chk($sformatf("frame_end_status_%02h", b), st, {30'd0, ovf_exp, 1'b0});
    endtask

    initial begin
        passed = 0;
        total = 0;
        memwr_count = 0;
        RES = 1'b0;
        bus.coreRead = 1'b0;
        bus.coreWrite = 1'b0;
        bus.coreAddr = 32'd0;
        bus.coreDataIn = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;

        // Reset then RAM traffic
        cyc();
        cyc();
        chk("reset_led", led, 32'd0);
        chk("reset_tx", {31'd0, uart_tx}, 32'd1);
        rd(A_STATUS, rdata);
        chk("reset_status", rdata, 32'd0);
        rd(A_CYCLE, rdata);
        chk("reset_cycle", rdata, 32'd0);
        RES = 1'b1;
        wr(32'h00000100, 32'h12345678);
        chk("ram_memwrite", {31'd0, wr_mem}, 32'd1);
        rd(32'h00000100, rdata);
        chk("ram_readback", rdata, 32'h12345678);
        chk("ram_memread", {31'd0, rd_mem}, 32'd1);
        chk("ram_memwr_count", memwr_count, 32'd1);
        chk("ram_led", led, 32'd0);
        chk("ram_tx", {31'd0, uart_tx}, 32'd1);

        // LED and CYCLE
        wr(A_LED, 32'hA5A5A5A5);
        chk("led_no_memwrite", {31'd0, wr_mem}, 32'd0);
        chk("led_value", led, 32'hA5A5A5A5);
        rd(A_LED, rdata);
        chk("led_read", rdata, 32'hA5A5A5A5);
        wr(A_CYCLE, 32'hFFFFFFFE);
        rd(A_CYCLE, rdata);
        chk("cycle_loaded", rdata, 32'hFFFFFFFE);
        cyc();
        rd(A_CYCLE, rdata);
        chk("cycle_plus1", rdata, 32'hFFFFFFFF);
        cyc();
        rd(A_CYCLE, rdata);
        chk("cycle_wrap", rdata, 32'h00000000);

        // UART frame 0x55
        rd(A_STATUS, rdata);
        chk("uart_idle_status", rdata, 32'd0);
        rd(A_TXDATA, rdata);
        chk("txdata_reads_zero", rdata, 32'd0);
        wr(A_TXDATA, 32'h00000055);
        frame_check(8'h55, 0, 1'b0);

        // Overflow: second byte dropped, OVF sticky until cleared
        wr(A_TXDATA, 32'h00000041);
        cyc();
        wr(A_TXDATA, 32'h00000042);
        rd(A_STATUS, rdata);
        chk("ovf_status", rdata, 32'h3);
        frame_check(8'h41, 2, 1'b1);
        wr(A_STATUS, 32'h2);
        rd(A_STATUS, rdata);
        chk("ovf_clear_idle", rdata, 32'h0);
        wr(A_TXDATA, 32'h00000043);
        wr(A_TXDATA, 32'h00000044);
        rd(A_STATUS, rdata);
        chk("ovf_status_2", rdata, 32'h3);
        wr(A_STATUS, 32'h2);
        frame_check(8'h43, 2, 1'b0);

        // Reset during DATA bit 3 of 0xA3 (bit 3 = 0), with OVF set
        wr(A_TXDATA, 32'h000000A3);
        repeat (7) cyc();
        wr(A_TXDATA, 32'h00000011);
        rd(A_STATUS, rdata);
        chk("midframe_ovf", rdata, 32'h3);
        repeat (8) cyc();
        chk("midframe_bit3", {31'd0, uart_tx}, 32'd0);
        RES = 1'b0;
        cyc();
        chk("abort_tx", {31'd0, uart_tx}, 32'd1);
        rd(A_STATUS, rdata);
        chk("abort_status", rdata, 32'd0);
        rd(A_CYCLE, rdata);
        chk("abort_cycle", rdata, 32'd0);
        chk("abort_led", led, 32'd0);
        RES = 1'b1;
        cyc();
        wr(A_TXDATA, 32'h0000000F);
        frame_check(8'h0F, 0, 1'b0);

        // Unmapped and simultaneous access
        rd(32'hFFFF0010, rdata);
        chk("unmapped_read", rdata, 32'd0);
        chk("unmapped_memread", {31'd0, rd_mem}, 32'd0);
        bus.coreAddr   = A_LED;
        bus.coreDataIn = 32'h3C3C3C3C;
        bus.coreRead   = 1'b1;
        bus.coreWrite  = 1'b1;
        #1;
        chk("rw_led_pre_edge", bus.coreDataOut, 32'd0);
        cyc();
        bus.coreRead  = 1'b0;
        bus.coreWrite = 1'b0;
        chk("rw_led_post_edge", led, 32'h3C3C3C3C);
        rd(A_STATUS, rdata);
        chk("rw_status_before", rdata, 32'd0);
        bus.coreAddr   = A_TXDATA;
        bus.coreDataIn = 32'h0000007E;
        bus.coreRead   = 1'b1;
        bus.coreWrite  = 1'b1;
        #1;
        chk("rw_txdata_read", bus.coreDataOut, 32'd0);
        chk("rw_txdata_no_mem", {30'd0, bus.memRead, bus.memWrite}, 32'd0);
        cyc();
        bus.coreRead  = 1'b0;
        bus.coreWrite = 1'b0;
        rd(A_STATUS, rdata);
        chk("rw_status_after", rdata, 32'h1);
        frame_check(8'h7E, 0, 1'b0);

        chk("final_memwr_count", memwr_count, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mmio_bus_bridge.md
Name: mmio_bus_bridge

Overview:
- Sits between `cpu_core` and `memory` inside `risc_v_cpu`, on the core's data-memory port.
- Decodes every core access. Routes it either to RAM or to a small memory-mapped I/O block: LED/check register, free-running cycle counter, and an 8N1 UART transmitter.
- Lets test programs print characters and time themselves without changing the core.
- Adds zero cycles of latency to RAM traffic.

Parameters:
- BAUD_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- MMIO_BASE, 16'hFFFF, value of addr[31:16] that selects the MMIO region.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RES  in  1  synchronous, active-low reset.
- coreRead  in  1  core read strobe.
- coreWrite  in  1  core write strobe.
- coreAddr  in  32  core byte address.
- coreDataIn  in  32  core write data.
- coreDataOut  out  32  read data returned to core.
- memRead  out  1  read strobe to memory.
- memWrite  out  1  write strobe to memory.
- memAddr  out  32  address to memory.
- memDataIn  out  32  write data to memory.
- memDataOut  in  32  read data from memory.
- led  out  32  LED/check register value.
- uart_tx  out  1  serial output; idles high.

Behaviour:
- Decode:
  - mmio = (coreAddr[31:16] == MMIO_BASE); otherwise the access is RAM.
  - MMIO register select uses coreAddr[15:2]; addr[1:0] are ignored. All accesses are 32-bit.
- RAM path:
  - memAddr = coreAddr and memDataIn = coreDataIn at all times.
  - memRead = coreRead & ~mmio; memWrite = coreWrite & ~mmio.
  - coreDataOut = memDataOut when ~mmio. Purely combinational, no added latency.
- MMIO map (word offsets):
  - 0x00 LED: read/write; the write takes effect at the clock edge.
  - 0x04 CYCLE: read returns the counter. A write loads coreDataIn; on the next cycle the counter increments from the loaded value.
  - 0x08 TXDATA: write-only, reads return 0. A write of bits [7:0] starts a transmit if the transmitter is idle. If busy, the byte is dropped and OVF is set.
  - 0x0C STATUS: read returns {30'b0, OVF, BUSY}. Writing 1 to bit 1 clears OVF. If a clear and an overflow occur in the same cycle, OVF stays set.
  - Other MMIO offsets: reads return 0, writes are ignored.
- MMIO reads are combinational from current register state. A read in the same cycle as an update returns the pre-edge value.
- When both coreRead and coreWrite are asserted, the write is performed and the read data is still returned.
- CYCLE: 32-bit, increments by 1 every cycle not being written, wraps 0xFFFFFFFF -> 0.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx = 1, BUSY = 0. An accepted TXDATA write latches the byte, clears the baud counter and bit index, and enters START on that edge.
  - START: uart_tx = 0 for BAUD_DIV cycles.
  - DATA: 8 bits, LSB first, each held BAUD_DIV cycles.
  - STOP: uart_tx = 1 for BAUD_DIV cycles, then IDLE.
  - BUSY = 1 in START, DATA and STOP.
  - Total frame = 10*BAUD_DIV cycles from the accepting edge until BUSY reads 0.
  - uart_tx is registered.
- Reset (RES == 0 at a rising edge):
  - led = 0, CYCLE = 0, OVF = 0, FSM = IDLE, uart_tx = 1, baud counter and bit index = 0.
  - Reset mid-frame aborts the frame; uart_tx returns high on that edge.
  - Core accesses during reset are ignored by MMIO. The RAM strobes still pass through.

Test Plan:
- Reset then RAM traffic: with RES low for 2 cycles, then high, write 0x12345678 to 0x00000100 and read it back -> memWrite pulses once with memAddr = 0x100; the read returns 0x12345678; led = 0; uart_tx = 1 throughout.
- LED/CYCLE: write 0xA5A5A5A5 to 0xFFFF0000 -> led = 0xA5A5A5A5 the next cycle and memWrite stays 0. Write 0xFFFFFFFE to 0xFFFF0004, then read it 2 cycles after the write edge -> 0x00000000 (wrapped).
- UART frame (BAUD_DIV = 4): write 0x55 to 0xFFFF0008 -> uart_tx sequence is 0 then bits 1,0,1,0,1,0,1,0 then 1, each level held for exactly 4 cycles. STATUS reads 0x1 during the frame and 0x0 exactly 40 cycles after the accepting edge.
- Overflow: write 0x41, then write 0x42 two cycles later -> the frame carries 0x41 only and STATUS = 0x3. Writing 0x2 to STATUS then clears it to 0x1 (or 0x0 once idle).
- Reset mid-frame: assert RES low during DATA bit 3 -> uart_tx = 1 and STATUS = 0 on the following edge. A subsequent write of 0x0F transmits a complete, correct frame.
- Unmapped and simultaneous access: reading 0xFFFF0010 -> 0, with memRead = 0. A TXDATA write in the same cycle as a STATUS read returns BUSY = 0; STATUS reads 0x1 on the next cycle.
